// File: rtl/seq_normalizer_16.sv
// Sequential 16-bit normalizer: shifts an accepted value one bit per cycle toward
// bit 15 (Sel=0) or bit 0 (Sel=1) until the target bit is set, reporting the shift count.
module seq_normalizer_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic        Sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Y,
    output logic [3:0]  S,
    output logic        zero,
    output logic        out_valid,
    input  logic        out_ready
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its data while valid is high, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] work;
    logic        dir;
    logic [3:0]  count;
    logic        accept;
    logic        handoff;
    logic        target_bit;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid & in_ready;
    assign handoff    = out_valid & out_ready;
    assign target_bit = dir ? work[0] : work[15];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if ((work == 16'h0000) || target_bit) state_nxt = DONE;
            DONE:    if (handoff) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= 16'h0000;
            dir   <= 1'b0;
            count <= 4'h0;
            Y     <= 16'h0000;
            S     <= 4'h0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        work  <= A;
                        dir   <= Sel;
                        count <= 4'h0;
                    end
                end
                SHIFT: begin
                    if (work == 16'h0000) begin
                        Y    <= 16'h0000;
                        S    <= 4'h0;
                        zero <= 1'b1;
                    end else if (target_bit) begin
                        Y    <= work;
                        S    <= count;
                        zero <= 1'b0;
                    end else begin
                        // A nonzero value reaches its target within 15 shifts, so count cannot wrap.
                        work  <= dir ? {1'b0, work[15:1]} : {work[14:0], 1'b0};
                        count <= count + 4'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
